// File: rtl/qdigit_pkg.sv
// qdigit_pkg
//   Shared definitions for the radix-4 division quotient path.
//   - FSM state encoding for the on-the-fly converter.
//   - Bit positions of the seven one-hot digit lines (-3..+3).
//   - Default number of quotient digits per division.
package qdigit_pkg;

  // Default number of radix-4 quotient digits per division
  localparam int NDIG_DEFAULT = 14;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_FIX   = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Bit index of each digit line inside the packed 7-bit digit vector.
  // Line index minus DIG_ZERO gives the signed digit value.
  localparam int DIG_N3   = 0;
  localparam int DIG_N2   = 1;
  localparam int DIG_N1   = 2;
  localparam int DIG_ZERO = 3;
  localparam int DIG_P1   = 4;
  localparam int DIG_P2   = 5;
  localparam int DIG_P3   = 6;
  localparam int NUM_DIG_LINES = 7;

endpackage

// File: rtl/qdigit_dec.sv
// qdigit_dec
//   Decodes the seven one-hot quotient digit lines into a signed digit.
//   Ports:
//     lines      in  7  one-hot digit lines, bit DIG_N3 (=-3) .. bit DIG_P3 (=+3)
//     digit      out 3  signed digit -3..+3; 0 when the lines are malformed
//     onehot_ok  out 1  exactly one line is set
module qdigit_dec
  import qdigit_pkg::*;
(
  input  logic [NUM_DIG_LINES-1:0] lines,
  output logic signed [2:0]        digit,
  output logic                     onehot_ok
);

  logic [2:0] ones;

  // Population count of the digit lines; only a count of one is legal
  always_comb begin
    ones = 3'd0;
    for (int i = 0; i < NUM_DIG_LINES; i++) begin
      ones = ones + 3'(lines[i]);
    end
  end

  assign onehot_ok = (ones == 3'd1);

  // Map the set line to its value; a malformed pattern decodes as zero
  // so the converter can treat it as an ordinary q=0 step.
  always_comb begin
    digit = 3'sd0;
    if (onehot_ok) begin
      if (lines[DIG_N3])      digit = -3'sd3;
      else if (lines[DIG_N2]) digit = -3'sd2;
      else if (lines[DIG_N1]) digit = -3'sd1;
      else if (lines[DIG_P1]) digit = 3'sd1;
      else if (lines[DIG_P2]) digit = 3'sd2;
      else if (lines[DIG_P3]) digit = 3'sd3;
      else                    digit = 3'sd0;
    end
  end

endmodule

// File: rtl/qdigit_otf.sv
// qdigit_otf
//   On-the-fly conversion of signed radix-4 quotient digits (-3..+3) into a
//   binary quotient, with final correction by the sign of the remainder.
//   Ports:
//     clk, rst           clock, asynchronous active-high reset
//     start              one-cycle pulse, begins (or aborts and restarts) a division
//     dig_vld            qualifies the one-hot digit lines mul_n3..mul_3
//     rem_vld, rem_neg   final remainder sign, accepted in FIX
//     quo                corrected quotient (QW bits), held until start/reset
//     quo_vld            one-cycle pulse when quo is new
//     busy               high whenever the FSM is not IDLE
//     err                sticky flag for a malformed (not one-hot) digit
module qdigit_otf
  import qdigit_pkg::*;
#(
  parameter int NDIG = NDIG_DEFAULT,
  parameter int QW   = 2 * NDIG
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dig_vld,
  input  logic          mul_n3,
  input  logic          mul_n2,
  input  logic          mul_n1,
  input  logic          mul_0,
  input  logic          mul_1,
  input  logic          mul_2,
  input  logic          mul_3,
  input  logic          rem_vld,
  input  logic          rem_neg,
  output logic [QW-1:0] quo,
  output logic          quo_vld,
  output logic          busy,
  output logic          err
);

  localparam int CW = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NDIG - 1);

  state_t                  state;
  logic [QW-1:0]           q_reg;
  logic [QW-1:0]           qm_reg;
  logic [QW-1:0]           q_nxt;
  logic [QW-1:0]           qm_nxt;
  logic [CW-1:0]           cnt;
  logic [NUM_DIG_LINES-1:0] lines;
  logic signed [2:0]       digit;
  logic signed [2:0]       digit_neg;
  logic [1:0]              mag;
  logic                    onehot_ok;

  assign lines = {mul_3, mul_2, mul_1, mul_0, mul_n1, mul_n2, mul_n3};

  qdigit_dec u_dec (
    .lines     (lines),
    .digit     (digit),
    .onehot_ok (onehot_ok)
  );

  // |q| for negative digits
  assign digit_neg = -digit;
  assign mag       = digit_neg[1:0];

  // Next Q/QM for the presented digit. Every update is 4*X plus a constant
  // in 0..3, so it reduces to a shift with the low two bits filled in; the
  // modulo-2^QW wrap comes for free from dropping the top two bits.
  //   q>0 : Q=4Q+q,        QM=4Q+q-1
  //   q=0 : Q=4Q,          QM=4QM+3
  //   q<0 : Q=4QM+4-|q|,   QM=4QM+3-|q|
  always_comb begin
    q_nxt  = q_reg;
    qm_nxt = qm_reg;
    if (digit == 3'sd0) begin
      q_nxt  = {q_reg[QW-3:0], 2'b00};
      qm_nxt = {qm_reg[QW-3:0], 2'b11};
    end else if (digit[2]) begin
      q_nxt  = {qm_reg[QW-3:0], 2'd0 - mag};
      qm_nxt = {qm_reg[QW-3:0], 2'd3 - mag};
    end else begin
      q_nxt  = {q_reg[QW-3:0], digit[1:0]};
      qm_nxt = {q_reg[QW-3:0], digit[1:0] - 2'd1};
    end
  end

  // FSM plus conversion registers. start has priority in every state, so a
  // start during ACCUM/FIX abandons the division without a quo_vld, and any
  // digit arriving alongside start is dropped. quo is only written on the
  // FIX->DONE transition so it holds the last result otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      q_reg   <= '0;
      qm_reg  <= '1;
      cnt     <= '0;
      quo     <= '0;
      quo_vld <= 1'b0;
      err     <= 1'b0;
    end else begin
      quo_vld <= 1'b0;
      if (start) begin
        state  <= ST_ACCUM;
        q_reg  <= '0;
        qm_reg <= '1;
        cnt    <= '0;
        err    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_IDLE;
          end
          ST_ACCUM: begin
            if (dig_vld) begin
              q_reg  <= q_nxt;
              qm_reg <= qm_nxt;
              cnt    <= cnt + 1'b1;
              if (!onehot_ok) err <= 1'b1;
              if (cnt == LAST_IDX) state <= ST_FIX;
            end
          end
          ST_FIX: begin
            if (rem_vld) begin
              quo     <= rem_neg ? qm_reg : q_reg;
              quo_vld <= 1'b1;
              state   <= ST_DONE;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/qdigit_otf.md
QDIGIT_OTF -- requirements
Module: qdigit_otf

Interface
REQ-001 Parameter NDIG, default 14, SHALL set the number of radix-4 quotient digits accepted per division.
REQ-002 Parameter QW, default 2*NDIG, SHALL set the quotient width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  input  1  SHALL be a one-cycle pulse that begins a new division.
REQ-006 dig_vld  input  1  SHALL qualify the digit inputs in the current cycle.
REQ-007 mul_n3, mul_n2, mul_n1, mul_0, mul_1, mul_2, mul_3  input  1 each  SHALL carry the one-hot quotient digit -3..+3.
REQ-008 rem_vld  input  1  SHALL qualify rem_neg.
REQ-009 rem_neg  input  1  SHALL indicate that the final partial remainder is negative.
REQ-010 quo  output  QW  SHALL present the corrected binary quotient.
REQ-011 quo_vld  output  1  SHALL be a one-cycle pulse marking quo as new.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.
REQ-013 err  output  1  SHALL be a sticky flag for a malformed digit.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, ACCUM, FIX, DONE.
REQ-015 Conversion registers Q and QM (QW bits each) SHALL maintain the invariant QM = Q-1 mod 2^QW.
REQ-016 On start in any state, the block SHALL set Q=0, QM=all-ones, cnt=0, err=0, and go to ACCUM on the next cycle.
REQ-017 Any digit presented in the same cycle as start SHALL be ignored.
REQ-018 In ACCUM, each cycle with dig_vld=1 SHALL accept digit q, increment cnt, and update Q and QM as follows:
- q>0: Q<=4Q+q; QM<=4Q+q-1.
- q=0: Q<=4Q; QM<=4QM+3.
- q<0: Q<=4QM+4-|q|; QM<=4QM+3-|q|.
REQ-019 All arithmetic SHALL be modulo 2^QW, with no overflow flag.
REQ-020 A dig_vld cycle whose seven digit lines are not exactly one-hot SHALL set err and SHALL be processed as q=0, still counting toward NDIG.
REQ-021 Accepting digit number NDIG SHALL move the FSM to FIX; while not in ACCUM, dig_vld SHALL be ignored.
REQ-022 In FIX, rem_vld=1 SHALL load quo<=(rem_neg ? QM : Q), drive quo_vld=1 in the next cycle, and move to DONE.
REQ-023 rem_vld outside FIX SHALL be ignored.
REQ-024 DONE SHALL return to IDLE after one cycle.
REQ-025 quo and err SHALL hold their values until the next start or reset.
REQ-026 Latency SHALL be one cycle from rem_vld to quo_vld, with no digit-side stall.
REQ-027 A start received in ACCUM or FIX SHALL abort the current division without asserting quo_vld.

Reset
REQ-028 When rst is asserted, the block SHALL immediately force state=IDLE, Q=0, QM=all-ones, cnt=0, quo=0, quo_vld=0, busy=0, err=0, independent of clk.
REQ-029 A reset in the middle of a division SHALL discard all partial results, and no quo_vld SHALL follow.

Structure
REQ-030 A shared division package SHALL hold the FSM state encoding, the digit-index constants (-3..+3), and the default NDIG.
REQ-031 One sub-module, qdigit_dec, SHALL decode the seven one-hot lines into a signed 3-bit digit plus an onehot_ok flag.
REQ-032 The conversion datapath and the FSM SHALL remain in qdigit_otf.

Verification
REQ-033 NDIG=3 (QW=6); digits +3, 0, -1; rem_neg=0 -> quo=0x2F (47), one quo_vld pulse, err=0.
REQ-034 Same digits with rem_neg=1 -> quo=0x2E (46).
REQ-035 NDIG=3; digits -1, -1, -1; rem_neg=0 -> quo=0x2B (wrap of -21); rem_neg=1 -> quo=0x2A.
REQ-036 Second digit presented with mul_1=mul_2=1 -> err=1 sticky; that digit is treated as 0; quo_vld still follows rem_vld.
REQ-037 start pulsed after two accepted digits -> no quo_vld; a fresh 3-digit sequence +1, +1, +1 with rem_neg=0 -> quo=0x15.
REQ-038 rst asserted mid-ACCUM without a clock edge -> busy=0 and quo=0 immediately; no quo_vld after release.
